// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor o = x - y, LSB digit first, valid/ready on both sides.
// Define MOD_CORRECT_EN to add m back digit-serially when x < y, giving (x - y) mod m.
module digit_serial_subtractor #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             borrow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
`ifdef MOD_CORRECT_EN
    FIX,
`endif
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] xs, ys, res;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             borrow_r;
  logic [DIGIT:0]   diff;
  logic             last;

  assign diff = {1'b0, xs[DIGIT-1:0]} - {1'b0, ys[DIGIT-1:0]} - {{DIGIT{1'b0}}, c};
  assign last = (cnt == LAST);

`ifdef MOD_CORRECT_EN
  logic [WIDTH-1:0] ms;
  logic [DIGIT:0]   sum;
  assign sum = {1'b0, res[DIGIT-1:0]} + {1'b0, ms[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
`else
  logic unused_m;
  assign unused_m = ^m;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SUB;
      SUB: begin
        if (last) begin
`ifdef MOD_CORRECT_EN
          state_nxt = diff[DIGIT] ? FIX : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MOD_CORRECT_EN
      FIX: if (last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      xs       <= '0;
      ys       <= '0;
      res      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      borrow_r <= 1'b0;
`ifdef MOD_CORRECT_EN
      ms       <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            xs  <= x;
            ys  <= y;
            cnt <= '0;
            c   <= 1'b0;
`ifdef MOD_CORRECT_EN
            ms  <= m;
`endif
          end
        end
        SUB: begin
          // Result digits enter from the top so digit 0 lands at the LSB after NDIG edges.
          xs  <= xs >> DIGIT;
          ys  <= ys >> DIGIT;
          res <= (res >> DIGIT) | (WIDTH'(diff[DIGIT-1:0]) << (WIDTH - DIGIT));
          c   <= diff[DIGIT];
          cnt <= cnt + CW'(1);
          if (last) begin
            borrow_r <= diff[DIGIT];
            cnt      <= '0;
            c        <= 1'b0;
          end
        end
`ifdef MOD_CORRECT_EN
        FIX: begin
          // Rotating the result through the adder replaces every digit in NDIG edges.
          ms  <= ms >> DIGIT;
          res <= (res >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
          c   <= sum[DIGIT];
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
            c   <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign o         = res;
  assign borrow    = borrow_r;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor: directed, back-pressure, reset and parameter sweeps.
// Compile with MOD_CORRECT_EN defined to also exercise the modular correction path.
module tb_digit_serial_subtractor;

`ifdef MOD_CORRECT_EN
  localparam bit MODF = 1'b1;
`else
  localparam bit MODF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_borrow;
  logic [63:0] a_x, a_y, a_m, a_o;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_borrow;
  logic [511:0] b_x, b_y, b_m, b_o;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_borrow;
  logic [7:0] c_x, c_y, c_m, c_o;

  digit_serial_subtractor #(.WIDTH(64), .DIGIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .m(a_m), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .o(a_o), .borrow(a_borrow));
  digit_serial_subtractor #(.WIDTH(512), .DIGIT(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .m(b_m), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .o(b_o), .borrow(b_borrow));
  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x(c_x), .y(c_y), .m(c_m), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .o(c_o), .borrow(c_borrow));

  // Reference: {borrow, (x - y [+ m if x < y]) mod 2^w}
  function automatic logic [512:0] model(input logic [511:0] xv, yv, mv, input int w);
    logic [511:0] mask, d;
    logic bw;
    mask = (w == 512) ? {512{1'b1}} : ((512'd1 << w) - 512'd1);
    bw = ((xv & mask) < (yv & mask));
    d = (xv & mask) - (yv & mask);
    if (MODF && bw) d = d + (mv & mask);
    return {bw, d & mask};
  endfunction

  function automatic int exp_lat(input int n, input logic bw);
    return (MODF && bw) ? 2 * n : n;
  endfunction

  task automatic a_start(input logic [63:0] xv, yv, mv);
    a_x = xv; a_y = yv; a_m = mv; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_x = ~xv; a_y = ~yv;
  endtask

  task automatic a_wait(output int lat, output bit saw_ready);
    lat = 0; saw_ready = 1'b0;
    do begin
      if (a_in_ready) saw_ready = 1'b1;
      @(posedge clk); #1; lat++;
    end while (!a_out_valid && lat < 200);
  endtask

  task automatic a_release();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_x = '0; a_y = '0; a_m = '0;
    b_in_valid = 0; b_out_ready = 0; b_x = '0; b_y = '0; b_m = '0;
    c_in_valid = 0; c_out_ready = 0; c_x = '0; c_y = '0; c_m = '0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", a_in_ready); end
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", a_out_valid); end
    vectors++; if (a_o !== 64'd0) begin miscompares++; $display("FAIL reset_o: got %h, expected 0", a_o); end
    vectors++; if (a_borrow !== 1'b0) begin miscompares++; $display("FAIL reset_borrow: got %b, expected 0", a_borrow); end
    vectors++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sweep_out_valid: got %b%b, expected 00", b_out_valid, c_out_valid); end
  endtask

  task automatic test_basic();
    logic [63:0] tx[3], ty[3], to[3];
    logic tb[3];
    int lat; bit saw;
    tx[0] = 64'h10; ty[0] = 64'h3; to[0] = 64'hD;                tb[0] = 1'b0;
    tx[1] = 64'h0;  ty[1] = 64'h1; to[1] = 64'hFFFFFFFFFFFFFFFF; tb[1] = 1'b1;
    tx[2] = 64'h0001000000000000; ty[2] = 64'h1; to[2] = 64'h0000FFFFFFFFFFFF; tb[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_start(tx[i], ty[i], 64'd0);
      a_wait(lat, saw);
      vectors++; if (a_o !== to[i]) begin miscompares++; $display("FAIL basic_o[%0d]: got %h, expected %h", i, a_o, to[i]); end
      vectors++; if (a_borrow !== tb[i]) begin miscompares++; $display("FAIL basic_borrow[%0d]: got %b, expected %b", i, a_borrow, tb[i]); end
      vectors++; if (lat != exp_lat(4, tb[i])) begin miscompares++; $display("FAIL basic_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat(4, tb[i])); end
      vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_busy[%0d]: got %b, expected 0", i, saw); end
      a_release();
    end
  endtask

  task automatic test_random64();
    logic [63:0] xv, yv, mv;
    logic [512:0] e;
    int lat; bit saw;
    for (int i = 0; i < 300; i++) begin
      xv = {$urandom, $urandom}; yv = {$urandom, $urandom}; mv = {$urandom, $urandom};
      if (i % 9 == 0) yv = xv;
      if (i % 11 == 0) yv = xv + 64'd1;
      e = model({448'd0, xv}, {448'd0, yv}, {448'd0, mv}, 64);
      a_start(xv, yv, mv);
      a_wait(lat, saw);
      vectors++; if (a_o !== e[63:0]) begin miscompares++; $display("FAIL rand64_o x=%h y=%h: got %h, expected %h", xv, yv, a_o, e[63:0]); end
      vectors++; if (a_borrow !== e[512]) begin miscompares++; $display("FAIL rand64_borrow x=%h y=%h: got %b, expected %b", xv, yv, a_borrow, e[512]); end
      vectors++; if (lat != exp_lat(4, e[512])) begin miscompares++; $display("FAIL rand64_latency: got %0d, expected %0d", lat, exp_lat(4, e[512])); end
      a_release();
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] o0, x2, y2;
    logic b0;
    logic [512:0] e;
    int lat; bit saw;
    a_start(64'h5, 64'h9, 64'd0);
    a_wait(lat, saw);
    o0 = 64'hFFFFFFFFFFFFFFFC; b0 = 1'b1;
    vectors++; if (a_o !== o0 || a_borrow !== b0) begin miscompares++; $display("FAIL bp_first: got %h/%b, expected %h/%b", a_o, a_borrow, o0, b0); end
    x2 = 64'h0; y2 = 64'h0;
    for (int i = 0; i < 6; i++) begin
      x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
      a_x = x2; a_y = y2; a_m = 64'd0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_handshake[%0d]: got out_valid=%b in_ready=%b, expected 1/0", i, a_out_valid, a_in_ready); end
      vectors++; if (a_o !== o0 || a_borrow !== b0) begin miscompares++; $display("FAIL bp_hold_result[%0d]: got %h/%b, expected %h/%b", i, a_o, a_borrow, o0, b0); end
    end
    a_release();
    vectors++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got out_valid=%b in_ready=%b, expected 0/1", a_out_valid, a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_wait(lat, saw);
    e = model({448'd0, x2}, {448'd0, y2}, 512'd0, 64);
    vectors++; if (a_o !== e[63:0] || a_borrow !== e[512]) begin miscompares++; $display("FAIL bp_next_op: got %h/%b, expected %h/%b", a_o, a_borrow, e[63:0], e[512]); end
    vectors++; if (lat != exp_lat(4, e[512])) begin miscompares++; $display("FAIL bp_next_latency: got %0d, expected %0d", lat, exp_lat(4, e[512])); end
    a_release();
  endtask

  task automatic test_reset_midop();
    int lat; bit saw, pulsed;
    a_start(64'h7, 64'h3, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_handshake: got out_valid=%b in_ready=%b, expected 0/1", a_out_valid, a_in_ready); end
    vectors++; if (a_o !== 64'd0 || a_borrow !== 1'b0) begin miscompares++; $display("FAIL midrst_result: got %h/%b, expected 0/0", a_o, a_borrow); end
    pulsed = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (a_out_valid) pulsed = 1'b1; end
    vectors++; if (pulsed !== 1'b0) begin miscompares++; $display("FAIL midrst_no_pulse: got %b, expected 0", pulsed); end
    a_start(64'h5, 64'h5, 64'd0);
    a_wait(lat, saw);
    vectors++; if (a_o !== 64'd0 || a_borrow !== 1'b0 || lat != 4) begin miscompares++; $display("FAIL midrst_follow: got %h/%b lat %0d, expected 0/0 lat 4", a_o, a_borrow, lat); end
    a_release();
  endtask

  task automatic test_sweep512();
    logic [511:0] xv, yv, mv;
    logic [512:0] e;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < 16; w++) begin
        xv[w*32 +: 32] = $urandom; yv[w*32 +: 32] = $urandom; mv[w*32 +: 32] = $urandom;
      end
      if (i % 7 == 0) yv = xv;
      if (i == 1) begin xv = '0; yv = '1; end
      e = model(xv, yv, mv, 512);
      b_x = xv; b_y = yv; b_m = mv; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!b_out_valid && lat < 200);
      vectors++; if (b_o !== e[511:0]) begin miscompares++; $display("FAIL sweep512_o[%0d]: got %h, expected %h", i, b_o, e[511:0]); end
      vectors++; if (b_borrow !== e[512]) begin miscompares++; $display("FAIL sweep512_borrow[%0d]: got %b, expected %b", i, b_borrow, e[512]); end
      vectors++; if (lat != exp_lat(16, e[512])) begin miscompares++; $display("FAIL sweep512_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat(16, e[512])); end
      b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] xv, yv, mv;
    logic [512:0] e;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      xv = 8'($urandom); yv = 8'($urandom); mv = 8'($urandom);
      if (i % 13 == 0) yv = xv;
      e = model({504'd0, xv}, {504'd0, yv}, {504'd0, mv}, 8);
      c_x = xv; c_y = yv; c_m = mv; c_in_valid = 1'b1;
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!c_out_valid && lat < 200);
      vectors++; if (c_o !== e[7:0]) begin miscompares++; $display("FAIL sweep8_o x=%h y=%h: got %h, expected %h", xv, yv, c_o, e[7:0]); end
      vectors++; if (c_borrow !== e[512]) begin miscompares++; $display("FAIL sweep8_borrow x=%h y=%h: got %b, expected %b", xv, yv, c_borrow, e[512]); end
      vectors++; if (lat != exp_lat(1, e[512])) begin miscompares++; $display("FAIL sweep8_latency: got %0d, expected %0d", lat, exp_lat(1, e[512])); end
      c_out_ready = 1'b1; @(posedge clk); #1; c_out_ready = 1'b0;
    end
  endtask

`ifdef MOD_CORRECT_EN
  task automatic test_mod_correct();
    int lat; bit saw;
    a_start(64'd3, 64'd5, 64'd13);
    a_wait(lat, saw);
    vectors++; if (a_o !== 64'd11 || a_borrow !== 1'b1) begin miscompares++; $display("FAIL mod_borrow_case: got %0d/%b, expected 11/1", a_o, a_borrow); end
    vectors++; if (lat != 8) begin miscompares++; $display("FAIL mod_borrow_latency: got %0d, expected 8", lat); end
    a_release();
    a_start(64'd9, 64'd4, 64'd13);
    a_wait(lat, saw);
    vectors++; if (a_o !== 64'd5 || a_borrow !== 1'b0) begin miscompares++; $display("FAIL mod_plain_case: got %0d/%b, expected 5/0", a_o, a_borrow); end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL mod_plain_latency: got %0d, expected 4", lat); end
    a_release();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random64();
    test_back_pressure();
    test_reset_midop();
`ifdef MOD_CORRECT_EN
    test_mod_correct();
`endif
    test_sweep512();
    test_sweep8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
